logic_unit_pipe: RTL and testbench
==================================

Name: logic_unit_pipe

Overview:
- Parametrised, pipelined bitwise logic unit. Eight operations selected by opcode on WIDTH-bit operands.
- Registered result with valid/ready handshake on both sides, optional accumulator feedback as operand B, zero/parity flags and a saturating transaction counter.
- Sits between the operand register file and the writeback stage of the datapath; replaces the fixed 16-bit combinational gate modules.

Parameters:
- WIDTH, 16, operand/result width in bits (>=1)
- CNT_W, 8, width of the saturating accepted-transaction counter

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  unit can accept a beat this cycle
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B (ignored when acc_sel=1)
- in_op  in  3  opcode
- acc_sel  in  1  use accumulator as operand B for this beat
- acc_clr  in  1  clear accumulator (single-cycle strobe, independent of handshake)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  WIDTH  registered result
- out_zero  out  1  out_data == 0
- out_parity  out  1  XOR-reduce of out_data
- acc_value  out  WIDTH  current accumulator contents
- txn_count  out  CNT_W  accepted beats, saturating

Behaviour:
- Async reset (rst=1, no clock needed): out_valid=0, out_data=0, out_zero=1, out_parity=0, acc_value=0, txn_count=0. in_ready=1 one cycle after rst deasserts.
- Reset mid-operation discards any held result. No beat is lost silently; upstream must re-issue.
- Opcodes: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 NOT A (B ignored), 7 PASS A.
- Operand B = acc_value when acc_sel=1, else in_b.
- Handshake and flow control:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept on in_valid && in_ready.
  - Latency exactly 1 cycle: on the accepting edge, out_data, out_zero and out_parity load the result, and out_valid=1.
  - Output is held stable while out_valid && !out_ready.
  - out_valid clears on out_ready with no new accept.
  - Simultaneous drain and accept (out_ready=1, in_valid=1) keeps out_valid=1 with the new result. Full throughput is 1 beat/cycle.
- Accumulator:
  - On every accepted beat with acc_sel=1, acc_value <= result.
  - acc_sel=0 beats leave it unchanged.
  - acc_clr=1 sets acc_value=0 on the next edge and has priority over a same-cycle acc_sel write. The beat itself still uses the pre-clear acc_value as operand B, and its result still goes to out_data.
- txn_count increments by 1 per accepted beat and saturates at 2^CNT_W-1 (no wrap). It is cleared only by rst.
- in_op, in_a, in_b and acc_sel are sampled only on the accepting edge. Values while in_ready=0 have no effect.
- No X propagation on outputs after reset. Unused opcode encodings do not exist (all 8 defined).

Test Plan:
- Reset then accept in_a=16'h00FF, in_b=16'h0F0F, op=0 with out_ready=1 -> next cycle out_valid=1, out_data=16'h000F, out_zero=0, out_parity=0, txn_count=1.
- Back-to-back ops 3,4,5 on A=16'hAAAA, B=16'hFFFF with out_ready=1 -> out_data 16'h5555, 16'h0000 (out_zero=1), 16'hAAAA on consecutive cycles; in_ready stays 1.
- Hold out_ready=0 after one result -> in_ready=0 and out_data stable for 5 cycles, an offered beat is not taken. Raise out_ready together with in_valid -> old result drains and the new result appears next cycle.
- Accumulate: acc_clr, then op=1 acc_sel=1 with A=16'h0001, then 16'h0100, then op=2 A=16'h0101 -> acc_value 16'h0001, 16'h0101, 16'h0000; the last result has out_zero=1.
- acc_clr asserted on the same cycle as an accepted acc_sel beat (acc=16'h00F0, A=16'h000F, op=1) -> out_data=16'h00FF, acc_value=0 next cycle.
- CNT_W=2: accept 6 beats -> txn_count 1,2,3,3,3,3. Then assert rst asynchronously while out_valid=1 -> out_valid, acc_value and txn_count drop to 0 immediately.

Source files
------------

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe
// Pipelined bitwise logic unit. Each accepted operand beat produces a
// registered result one cycle later, held until downstream takes it.
//
// Ports:
//   clk, rst     rising-edge clock, asynchronous active-high reset
//   in_valid     operand beat offered by upstream
//   in_ready     unit can take a beat this cycle
//   in_a, in_b   operands (in_b is replaced by acc_value when acc_sel=1)
//   in_op        opcode: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR,
//                6 NOT A, 7 PASS A
//   acc_sel      use the accumulator as operand B for this beat
//   acc_clr      single-cycle strobe clearing the accumulator
//   out_valid    result register holds a result
//   out_ready    downstream takes the result this cycle
//   out_data     registered result
//   out_zero     out_data == 0
//   out_parity   XOR-reduce of out_data
//   acc_value    accumulator contents
//   txn_count    accepted beats, saturating at all-ones
//
// Handshake (both sides): a transfer happens on a rising edge where valid
// and ready are both high. in_ready = !out_valid || out_ready, so a result
// leaving and a new beat entering on the same edge sustains 1 beat/cycle,
// and a stalled result stays stable until downstream takes it.
module logic_unit_pipe #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [2:0]       in_op,
   input  logic             acc_sel,
   input  logic             acc_clr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_zero,
   output logic             out_parity,
   output logic [WIDTH-1:0] acc_value,
   output logic [CNT_W-1:0] txn_count
);

   typedef enum logic [2:0] {
      OP_AND  = 3'd0,
      OP_OR   = 3'd1,
      OP_XOR  = 3'd2,
      OP_NAND = 3'd3,
      OP_NOR  = 3'd4,
      OP_XNOR = 3'd5,
      OP_NOTA = 3'd6,
      OP_PASS = 3'd7
   } opCode_e;

   logic             acceptBeat;
   logic [WIDTH-1:0] operandB;
   logic [WIDTH-1:0] result;
   logic             countFull;

   assign in_ready   = !out_valid || out_ready;
   assign acceptBeat = in_valid && in_ready;
   assign operandB   = acc_sel ? acc_value : in_b;
   assign countFull  = &txn_count;

   always_comb begin
      result = '0;
      unique case (opCode_e'(in_op))
         OP_AND:  result = in_a & operandB;
         OP_OR:   result = in_a | operandB;
         OP_XOR:  result = in_a ^ operandB;
         OP_NAND: result = ~(in_a & operandB);
         OP_NOR:  result = ~(in_a | operandB);
         OP_XNOR: result = ~(in_a ^ operandB);
         OP_NOTA: result = ~in_a;
         OP_PASS: result = in_a;
         default: result = '0;
      endcase
   end

   // Result register. Flags are registered alongside the data so they can
   // never disagree with out_data, including while a result is stalled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_zero   <= 1'b1;
         out_parity <= 1'b0;
      end else if (acceptBeat) begin
         out_valid  <= 1'b1;
         out_data   <= result;
         out_zero   <= (result == '0);
         out_parity <= ^result;
      end else if (out_ready) begin
         out_valid  <= 1'b0;
      end
   end

   // The clear strobe wins over a same-edge accumulate; the beat itself
   // already used the old accumulator value as its operand B.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_value <= '0;
      end else if (acc_clr) begin
         acc_value <= '0;
      end else if (acceptBeat && acc_sel) begin
         acc_value <= result;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         txn_count <= '0;
      end else if (acceptBeat && !countFull) begin
         txn_count <= txn_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb_logic_unit_pipe
// Bench for logic_unit_pipe: a default-width instance plus a CNT_W=2
// instance sharing the same stimulus, a reference model driven from the
// operation truth tables, a per-cycle compare process and directed checks.
module tb_logic_unit_pipe;

   localparam int W = 16;

   // clock / reset
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic          in_valid = 1'b0;
   logic [W-1:0]  in_a = '0;
   logic [W-1:0]  in_b = '0;
   logic [2:0]    in_op = '0;
   logic          acc_sel = 1'b0;
   logic          acc_clr = 1'b0;
   logic          out_ready = 1'b0;

   logic          in_ready, out_valid, out_zero, out_parity;
   logic [W-1:0]  out_data, acc_value;
   logic [7:0]    txn_count;

   logic          sInReady, sOutValid, sOutZero, sOutParity;
   logic [W-1:0]  sOutData, sAccValue;
   logic [1:0]    sTxnCount;

   logic_unit_pipe #(.WIDTH(W), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_op(in_op), .acc_sel(acc_sel),
      .acc_clr(acc_clr), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_zero(out_zero), .out_parity(out_parity),
      .acc_value(acc_value), .txn_count(txn_count)
   );

   logic_unit_pipe #(.WIDTH(W), .CNT_W(2)) dutSmall (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(sInReady),
      .in_a(in_a), .in_b(in_b), .in_op(in_op), .acc_sel(acc_sel),
      .acc_clr(acc_clr), .out_valid(sOutValid), .out_ready(out_ready),
      .out_data(sOutData), .out_zero(sOutZero), .out_parity(sOutParity),
      .acc_value(sAccValue), .txn_count(sTxnCount)
   );

   int nChecks = 0;
   int nFails  = 0;
   logic chkOn = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // reference model: per-bit truth table indexed by {a,b}
   function automatic logic [W-1:0] refOp(input logic [2:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
      logic [3:0] tt [8];
      logic [W-1:0] r;
      tt[0] = 4'b1000; tt[1] = 4'b1110; tt[2] = 4'b0110; tt[3] = 4'b0111;
      tt[4] = 4'b0001; tt[5] = 4'b1001; tt[6] = 4'b0011; tt[7] = 4'b1100;
      for (int i = 0; i < W; i++) r[i] = tt[op][{a[i], b[i]}];
      return r;
   endfunction

   function automatic logic oddOnes(input logic [W-1:0] v);
      int ones = 0;
      for (int i = 0; i < W; i++) if (v[i]) ones++;
      return (ones % 2) == 1;
   endfunction

   logic         mValid = 1'b0;
   logic [W-1:0] mData  = '0;
   logic [W-1:0] mAcc   = '0;
   int           mCnt   = 0;
   int           mCntS  = 0;

   always @(posedge clk or posedge rst) begin
      logic take;
      logic [W-1:0] r;
      if (rst) begin
         mValid = 1'b0; mData = '0; mAcc = '0; mCnt = 0; mCntS = 0;
      end else begin
         take = in_valid && (!mValid || out_ready);
         r = refOp(in_op, in_a, acc_sel ? mAcc : in_b);
         if (take) begin
            mValid = 1'b1;
            mData  = r;
            if (mCnt < 255) mCnt++;
            if (mCntS < 3) mCntS++;
         end else if (out_ready) begin
            mValid = 1'b0;
         end
         if (acc_clr) mAcc = '0;
         else if (take && acc_sel) mAcc = r;
      end
   end

   // per-cycle scoreboard compare
   always @(negedge clk) begin
      if (chkOn) begin
         chk("m_in_ready", in_ready, !mValid || out_ready);
         chk("m_out_valid", out_valid, mValid);
         chk("m_out_data", out_data, mData);
         chk("m_out_zero", out_zero, mData == '0);
         chk("m_out_parity", out_parity, oddOnes(mData));
         chk("m_acc_value", acc_value, mAcc);
         chk("m_txn_count", txn_count, mCnt);
         chk("m_small_txn", sTxnCount, mCntS);
         chk("m_small_data", sOutData, mData);
      end
   end

   // driver tasks
   task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2:0] op, input logic sel, input logic clr);
      in_valid = v; in_a = a; in_b = b; in_op = op; acc_sel = sel; acc_clr = clr;
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   initial begin
      #1 rst = 1'b1;
      #1;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_data", out_data, 16'h0000);
      chk("rst_out_zero", out_zero, 1'b1);
      chk("rst_out_parity", out_parity, 1'b0);
      chk("rst_acc", acc_value, 16'h0000);
      chk("rst_txn", txn_count, 8'd0);
      step();
      rst = 1'b0;
      chkOn = 1'b1;
      step();
      chk("post_rst_in_ready", in_ready, 1'b1);

      // first beat: AND
      out_ready = 1'b1;
      drive(1, 16'h00FF, 16'h0F0F, 3'd0, 0, 0);
      step();
      chk("and_valid", out_valid, 1'b1);
      chk("and_data", out_data, 16'h000F);
      chk("and_zero", out_zero, 1'b0);
      chk("and_parity", out_parity, 1'b0);
      chk("and_txn", txn_count, 8'd1);

      // back-to-back NAND, NOR, XNOR
      drive(1, 16'hAAAA, 16'hFFFF, 3'd3, 0, 0);
      step();
      chk("nand_data", out_data, 16'h5555);
      chk("b2b_ready1", in_ready, 1'b1);
      drive(1, 16'hAAAA, 16'hFFFF, 3'd4, 0, 0);
      step();
      chk("nor_data", out_data, 16'h0000);
      chk("nor_zero", out_zero, 1'b1);
      drive(1, 16'hAAAA, 16'hFFFF, 3'd5, 0, 0);
      step();
      chk("xnor_data", out_data, 16'hAAAA);
      chk("xnor_valid", out_valid, 1'b1);

      // backpressure
      drive(1, 16'h1234, 16'h0000, 3'd7, 0, 0);
      step();
      out_ready = 1'b0;
      drive(1, 16'h5678, 16'h0000, 3'd7, 0, 0);
      for (int i = 0; i < 5; i++) begin
         step();
         chk("stall_in_ready", in_ready, 1'b0);
         chk("stall_data", out_data, 16'h1234);
         chk("stall_valid", out_valid, 1'b1);
      end
      out_ready = 1'b1;
      step();
      chk("drain_accept_data", out_data, 16'h5678);
      chk("drain_accept_valid", out_valid, 1'b1);
      drive(0, 16'h0000, 16'h0000, 3'd0, 0, 0);
      step();
      chk("drain_valid", out_valid, 1'b0);

      // accumulate
      drive(0, 16'h0000, 16'h0000, 3'd0, 0, 1);
      step();
      chk("acc_clr", acc_value, 16'h0000);
      drive(1, 16'h0001, 16'hFFFF, 3'd1, 1, 0);
      step();
      chk("acc_1", acc_value, 16'h0001);
      drive(1, 16'h0100, 16'hFFFF, 3'd1, 1, 0);
      step();
      chk("acc_2", acc_value, 16'h0101);
      drive(1, 16'h0101, 16'hFFFF, 3'd2, 1, 0);
      step();
      chk("acc_3", acc_value, 16'h0000);
      chk("acc_3_zero", out_zero, 1'b1);

      // clear with a same-cycle accumulate
      drive(1, 16'h00F0, 16'h0000, 3'd7, 1, 0);
      step();
      chk("acc_load", acc_value, 16'h00F0);
      drive(1, 16'h000F, 16'h0000, 3'd1, 1, 1);
      step();
      chk("clr_pri_data", out_data, 16'h00FF);
      chk("clr_pri_acc", acc_value, 16'h0000);
      drive(0, 16'h0000, 16'h0000, 3'd0, 0, 0);
      step();

      // random traffic against the model
      for (int i = 0; i < 60; i++) begin
         drive($urandom_range(0, 1), W'($urandom), W'($urandom), 3'($urandom_range(0, 7)),
               $urandom_range(0, 1), $urandom_range(0, 7) == 0);
         out_ready = $urandom_range(0, 3) != 0;
         step();
      end
      drive(0, 16'h0000, 16'h0000, 3'd0, 0, 0);
      out_ready = 1'b1;
      step();

      // saturating counter and asynchronous reset with a held result
      rst = 1'b1;
      #1 rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         drive(1, 16'hABCD, 16'h0000, 3'd7, 1, 0);
         step();
         chk("sat_small_txn", sTxnCount, (i < 3) ? i + 1 : 3);
         chk("sat_txn", txn_count, i + 1);
      end
      drive(0, 16'h0000, 16'h0000, 3'd0, 0, 0);
      out_ready = 1'b0;
      step();
      chk("hold_valid", out_valid, 1'b1);
      chk("hold_acc", acc_value, 16'hABCD);
      #2 rst = 1'b1;
      #1;
      chk("arst_valid", out_valid, 1'b0);
      chk("arst_acc", acc_value, 16'h0000);
      chk("arst_txn", txn_count, 8'd0);
      chk("arst_small_txn", sTxnCount, 2'd0);
      chk("arst_data", out_data, 16'h0000);
      step();
      rst = 1'b0;
      step();
      step();
      chkOn = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
      $finish;
   end

endmodule
